// File: rtl/eth_pkg.sv
// Shared Ethernet/ARP receive definitions.
// Contents: frame constants (preamble/SFD bytes, header and ARP payload
// lengths, EtherType, opcodes, broadcast MAC) and the receive FSM state type.
package eth_pkg;

  localparam logic [15:0] ETH_TYPE_ARP  = 16'h0806;
  localparam logic [15:0] ARP_OP_REQ    = 16'd1;
  localparam logic [15:0] ARP_OP_REPLY  = 16'd2;

  localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0]  SFD_BYTE      = 8'hD5;
  localparam int          PREAMBLE_LEN  = 7;
  localparam int          ETH_HEAD_LEN  = 14;
  localparam int          ARP_LEN       = 28;

  localparam logic [47:0] BCAST_MAC     = 48'hFF_FF_FF_FF_FF_FF;

  typedef enum logic [2:0] {
    IDLE,
    PREAMBLE,
    ETH_HEAD,
    ARP_DATA,
    RX_END
  } rx_state_t;

endpackage

// File: rtl/arp_rx.sv
// GMII receive-side ARP parser.
// Strips preamble/SFD, filters on destination MAC (local or broadcast) and
// EtherType 0x0806, then parses the 28-byte ARP payload. A request or reply
// whose target IP matches BOARD_IP raises arp_rx_done for one cycle and
// updates the sender fields; everything else is silently dropped.
// Padding and FCS are skipped; CRC is not checked here.
//
// Ports:
//   gmii_rx_clk  in   receive clock, sole clock
//   rst_n        in   synchronous active-low reset
//   gmii_rx_dv   in   receive data valid
//   gmii_rxd     in   receive byte
//   arp_rx_done  out  one-cycle pulse per accepted frame
//   arp_rx_type  out  0 = request, 1 = reply (held)
//   src_mac      out  sender hardware address (held)
//   src_ip       out  sender protocol address (held)
module arp_rx
  import eth_pkg::*;
#(
  parameter logic [47:0] BOARD_MAC = 48'h00_11_22_33_44_55,
  parameter logic [31:0] BOARD_IP  = {8'd192, 8'd168, 8'd1, 8'd10}
) (
  input  logic        gmii_rx_clk,
  input  logic        rst_n,
  input  logic        gmii_rx_dv,
  input  logic [7:0]  gmii_rxd,
  output logic        arp_rx_done,
  output logic        arp_rx_type,
  output logic [47:0] src_mac,
  output logic [31:0] src_ip
);

  localparam logic [4:0] PRE_LAST = 5'(PREAMBLE_LEN);
  localparam logic [4:0] ETH_LAST = 5'(ETH_HEAD_LEN - 1);
  localparam logic [4:0] ARP_LAST = 5'(ARP_LEN - 1);

  rx_state_t   state;
  logic [4:0]  cnt;
  logic [39:0] dst_sr;
  logic [7:0]  type_hi;
  logic [15:0] op_sr;
  logic [47:0] smac_sr;
  logic [31:0] sip_sr;
  logic [23:0] tip_sr;

  // The last byte of each checked field is compared straight off the bus,
  // so the decision lands on the same edge that samples that byte.
  logic dst_ok;
  logic type_ok;
  logic op_ok;
  logic ip_ok;

  always_comb begin
    dst_ok  = ({dst_sr, gmii_rxd} == BOARD_MAC) || ({dst_sr, gmii_rxd} == BCAST_MAC);
    type_ok = ({type_hi, gmii_rxd} == ETH_TYPE_ARP);
    op_ok   = (op_sr == ARP_OP_REQ) || (op_sr == ARP_OP_REPLY);
    ip_ok   = ({tip_sr, gmii_rxd} == BOARD_IP);
  end

  always_ff @(posedge gmii_rx_clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      dst_sr      <= '0;
      type_hi     <= '0;
      op_sr       <= '0;
      smac_sr     <= '0;
      sip_sr      <= '0;
      tip_sr      <= '0;
      arp_rx_done <= 1'b0;
      arp_rx_type <= 1'b0;
      src_mac     <= '0;
      src_ip      <= '0;
    end else begin
      arp_rx_done <= 1'b0;
      case (state)
        IDLE: begin
          if (gmii_rx_dv && gmii_rxd == PREAMBLE_BYTE) begin
            state <= PREAMBLE;
            cnt   <= 5'd1;
          end
        end

        // cnt holds the number of 0x55 bytes seen; exactly seven precede SFD.
        PREAMBLE: begin
          if (!gmii_rx_dv) begin
            state <= IDLE;
            cnt   <= '0;
          end else if (gmii_rxd == PREAMBLE_BYTE && cnt < PRE_LAST) begin
            cnt <= cnt + 5'd1;
          end else if (gmii_rxd == SFD_BYTE && cnt == PRE_LAST) begin
            state <= ETH_HEAD;
            cnt   <= '0;
          end else begin
            state <= RX_END;
            cnt   <= '0;
          end
        end

        ETH_HEAD: begin
          if (!gmii_rx_dv) begin
            state <= IDLE;
            cnt   <= '0;
          end else begin
            if (cnt < 5'd5)   dst_sr  <= {dst_sr[31:0], gmii_rxd};
            if (cnt == 5'd12) type_hi <= gmii_rxd;
            if (cnt == 5'd5 && !dst_ok) begin
              state <= RX_END;
              cnt   <= '0;
            end else if (cnt == ETH_LAST) begin
              state <= type_ok ? ARP_DATA : RX_END;
              cnt   <= '0;
            end else begin
              cnt <= cnt + 5'd1;
            end
          end
        end

        ARP_DATA: begin
          if (!gmii_rx_dv) begin
            state <= IDLE;
            cnt   <= '0;
          end else begin
            if (cnt == 5'd6 || cnt == 5'd7)  op_sr   <= {op_sr[7:0], gmii_rxd};
            if (cnt >= 5'd8 && cnt <= 5'd13)  smac_sr <= {smac_sr[39:0], gmii_rxd};
            if (cnt >= 5'd14 && cnt <= 5'd17) sip_sr  <= {sip_sr[23:0], gmii_rxd};
            if (cnt >= 5'd24 && cnt <= 5'd26) tip_sr  <= {tip_sr[15:0], gmii_rxd};
            if (cnt == ARP_LAST) begin
              if (ip_ok && op_ok) begin
                arp_rx_done <= 1'b1;
                arp_rx_type <= (op_sr == ARP_OP_REPLY);
                src_mac     <= smac_sr;
                src_ip      <= sip_sr;
              end
              state <= RX_END;
              cnt   <= '0;
            end else begin
              cnt <= cnt + 5'd1;
            end
          end
        end

        // Swallow padding, FCS and anything else until the line goes idle.
        RX_END: begin
          if (!gmii_rx_dv) begin
            state <= IDLE;
            cnt   <= '0;
          end
        end

        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule
